// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus types for the sprite DMA arbiter: FSM states, register addresses, index/page types.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR_DEF = 16'h2004;

    typedef logic [7:0] byte_idx_t;
    typedef logic [7:0] page_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA bus arbiter: CPU write to the DMA register stalls the CPU and copies one page to OAMDATA.
// Latency: bus pass-through is combinational; a copy stalls the CPU 513 or 514 cycles depending on parity.
// Backpressure: cpu_rdy low for the whole copy; CPU-side writes while busy are dropped.
module oam_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [ADDR_W-1:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dma_busy
);

    dma_state_t        state_q, state_d;
    logic              parity_q;
    byte_idx_t         idx_q, idx_d;
    page_t             page_q, page_d;
    logic [DATA_W-1:0] data_latch_q, data_latch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            parity_q     <= 1'b0;
            idx_q        <= '0;
            page_q       <= '0;
            data_latch_q <= '0;
        end else begin
            state_q      <= state_d;
            parity_q     <= ~parity_q;
            idx_q        <= idx_d;
            page_q       <= page_d;
            data_latch_q <= data_latch_d;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        page_d       = page_q;
        data_latch_d = data_latch_q;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_we       = 1'b0;
        cpu_rdy      = 1'b0;
        dma_busy     = 1'b1;

        unique case (state_q)
            IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
                mem_we   = cpu_we;
                // The triggering write is still forwarded to memory above.
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_wdata[7:0];
                    idx_d   = '0;
                    state_d = HALT;
                end
            end
            HALT: begin
                // Reads must land on even-parity cycles; insert ALIGN otherwise.
                state_d = parity_q ? READ : ALIGN;
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                mem_addr     = {page_q, idx_q};
                data_latch_d = mem_rdata;
                state_d      = WRITE;
            end
            WRITE: begin
                mem_addr  = OAMDATA_ADDR;
                mem_wdata = data_latch_q;
                mem_we    = 1'b1;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: behavioural memory, page-copy reference model, directed + randomized DMA runs.
module tb_oam_dma_arbiter;
    import nes_bus_pkg::*;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM     = 16'h2004;
    localparam logic [15:0] IDLE_RD = 16'h8000;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_busy;

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .dma_busy  (dma_busy)
    );

    logic [7:0]  mem [0:65535];
    logic [7:0]  snap [0:255];
    logic [7:0]  wq [$];
    logic [15:0] rq [$];
    int          stall_cnt;
    int          w2004_cnt;
    int          zero_acc;
    int          cyc;
    int          checks;
    int          errors;

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the design's parity equals cyc[0] within a cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
    endtask

    // Launch a copy so that HALT falls on the requested parity; returns that parity.
    task automatic start_dma(input logic [7:0] pg, input bit want_odd, output bit halt_odd);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (((cyc + 1) % 2) == int'(want_odd)) break;
        end
        halt_odd = ((cyc + 1) % 2) == 1;
        for (int i = 0; i < 256; i++) snap[i] = mem[{pg, 8'(i)}];
        stall_cnt = 0;
        wq.delete();
        rq.delete();
        zero_acc  = 0;
        drive(DMA_REG, pg, 1'b1);
        @(posedge clk); #1;
        drive(IDLE_RD, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!dma_busy) begin done = 1; break; end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic verify_dma(input string tag, input logic [7:0] pg, input int exp_stall);
        int bad_w = 0;
        int bad_r = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < wq.size() && wq[i] !== snap[i]) bad_w++;
            if (i < rq.size() && rq[i] !== {pg, 8'(i)}) bad_r++;
        end
        check({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_nwr"}, 32'(wq.size()), 32'd256);
        check({tag, "_nrd"}, 32'(rq.size()), 32'd256);
        check({tag, "_wdata_bad"}, 32'(bad_w), 32'd0);
        check({tag, "_raddr_bad"}, 32'(bad_r), 32'd0);
        check({tag, "_rdy_after"}, 32'(cpu_rdy), 32'd1);
    endtask

    initial begin
        bit          hp;
        logic [7:0]  pg;
        logic [7:0]  d;
        logic [15:0] a;
        int          w_before;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(16'h1234, 8'h77, 1'b0);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        fork
            forever begin
                @(posedge clk);
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
            forever begin
                @(negedge clk);
                if (!cpu_rdy) stall_cnt++;
                if (mem_we && mem_addr == OAM) begin
                    w2004_cnt++;
                    if (dma_busy) wq.push_back(mem_wdata);
                end
                if (dma_busy && !mem_we && mem_addr != cpu_addr) rq.push_back(mem_addr);
                if (dma_busy && mem_addr == 16'h0000) zero_acc++;
            end
        join_none

        // Reset state
        #3;
        check("rst_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_busy", 32'(dma_busy), 32'd0);
        check("rst_addr_pass", 32'(mem_addr), 32'h1234);
        check("rst_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pass-through: random reads, read of DMA reg, write to 4015
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            a = 16'($urandom_range(16'h0000, 16'h3FFF));
            drive(a, 8'h00, 1'b0);
            @(negedge clk);
            check("pt_rd_addr", 32'(mem_addr), 32'(a));
            check("pt_rd_data", 32'(cpu_rdata), 32'(mem[a]));
        end
        @(posedge clk); #1;
        drive(DMA_REG, 8'h02, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rd4014_busy", 32'(dma_busy), 32'd0);
        check("rd4014_rdy", 32'(cpu_rdy), 32'd1);
        @(posedge clk); #1;
        d = 8'($urandom);
        drive(16'h4015, d, 1'b1);
        @(negedge clk);
        check("wr4015_we", 32'(mem_we), 32'd1);
        check("wr4015_wdata", 32'(mem_wdata), 32'(d));
        @(posedge clk); #1;
        drive(IDLE_RD, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check("wr4015_mem", 32'(mem[16'h4015]), 32'(d));
        check("wr4015_busy", 32'(dma_busy), 32'd0);

        // Page 02, HALT on odd parity
        start_dma(8'h02, 1'b1, hp);
        wait_idle("odd");
        verify_dma("odd", 8'h02, hp ? 513 : 514);
        check("odd_halt_par", 32'(hp), 32'd1);
        check("odd_first", 32'(wq.size() > 0 ? wq[0] : 8'h00), 32'h5A);
        check("odd_last", 32'(wq.size() > 255 ? wq[255] : 8'h00), 32'hA5);
        check("odd_trig_to_mem", 32'(mem[DMA_REG]), 32'h02);

        // Same page, HALT on even parity
        start_dma(8'h02, 1'b0, hp);
        wait_idle("even");
        verify_dma("even", 8'h02, hp ? 513 : 514);
        check("even_halt_par", 32'(hp), 32'd0);

        // Last page
        start_dma(8'hFF, 1'($urandom), hp);
        wait_idle("pgff");
        verify_dma("pgff", 8'hFF, hp ? 513 : 514);
        check("pgff_last_rd", 32'(rq.size() > 0 ? rq[rq.size() - 1] : 16'h0), 32'hFFFF);
        check("pgff_zero_acc", 32'(zero_acc), 32'd0);

        // Random pages and parities
        for (int k = 0; k < 2; k++) begin
            pg = 8'($urandom_range(8'h04, 8'h1F));
            start_dma(pg, 1'($urandom), hp);
            wait_idle("rnd");
            verify_dma("rnd", pg, hp ? 513 : 514);
        end

        // Write to DMA reg while busy is ignored
        start_dma(8'h02, 1'($urandom), hp);
        repeat (40) @(posedge clk);
        #1;
        drive(DMA_REG, 8'h03, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        drive(IDLE_RD, 8'h00, 1'b0);
        wait_idle("restart");
        verify_dma("restart", 8'h02, hp ? 513 : 514);
        check("restart_reg_mem", 32'(mem[DMA_REG]), 32'h02);

        // Reset after the 100th write aborts the copy
        start_dma(8'h02, 1'($urandom), hp);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (wq.size() >= 100) break;
        end
        check("abort_reached100", 32'(wq.size()), 32'd100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_rdy", 32'(cpu_rdy), 32'd1);
        check("abort_busy", 32'(dma_busy), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        w_before = w2004_cnt;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_more_wr", 32'(w2004_cnt), 32'(w_before));
        check("abort_wq", 32'(wq.size()), 32'd100);
        start_dma(8'h02, 1'($urandom), hp);
        wait_idle("fresh");
        verify_dma("fresh", 8'h02, hp ? 513 : 514);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
